// File: rtl/cmac_pkg.sv
// Shared constants and width helpers for the pipelined complex MAC.
// Nothing here is clocked; the top and the multiplier core import it to
// derive their internal widths from DW / ACC_LOG2.
package cmac_pkg;

  localparam int DW_DEF       = 8;
  localparam int ACC_LOG2_DEF = 4;

  // Full-precision complex product term: sum/difference of two 2*DW products.
  function automatic int calc_tw(input int dw);
    return 2 * dw + 1;
  endfunction

  // Output width: term width plus headroom for 2^acc_log2 accumulated beats.
  function automatic int calc_ow(input int dw, input int acc_log2);
    return 2 * dw + 1 + acc_log2;
  endfunction

  localparam int TERM_W  = calc_tw(DW_DEF);
  localparam int CNT_LIM = 2 ** ACC_LOG2_DEF;

endpackage

// File: rtl/complex_mult_core.sv
// Stages S0..S2 of the complex MAC: input capture, four real products, then
// the re/im combination (optionally against the conjugate of B).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset (valid bits only)
//   i_en                 pipeline advance enable (low = whole pipe holds)
//   i_valid/i_last/i_conj  beat qualifiers
//   i_a..i_d             signed operands, A = a+jb, B = c+jd
//   o_term_re/o_term_im  signed 2*DW+1 product term at S2
//   o_last/o_valid       S2 qualifiers
module complex_mult_core import cmac_pkg::*; #(
  parameter  int DW = DW_DEF,
  localparam int TW = calc_tw(DW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic                 i_conj,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  input  logic signed [DW-1:0] i_c,
  input  logic signed [DW-1:0] i_d,
  output logic signed [TW-1:0] o_term_re,
  output logic signed [TW-1:0] o_term_im,
  output logic                 o_last,
  output logic                 o_valid
);

  logic [2:0]            vld_pipe;
  logic [2:0]            r_last_pipe;
  logic [1:0]            r_conj_pipe;
  logic signed [DW-1:0]  r_a, r_b, r_c, r_d;
  logic signed [2*DW-1:0] r_ac, r_bd, r_ad, r_bc;
  logic signed [TW-1:0]  w_ac, w_bd, w_ad, w_bc;
  logic signed [TW-1:0]  r_re, r_im;

  // Sign-extend the products by one bit so -128*-128 terms cannot wrap.
  assign w_ac = {r_ac[2*DW-1], r_ac};
  assign w_bd = {r_bd[2*DW-1], r_bd};
  assign w_ad = {r_ad[2*DW-1], r_ad};
  assign w_bc = {r_bc[2*DW-1], r_bc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (i_en) begin
      vld_pipe <= {vld_pipe[1:0], i_valid};
    end
  end

  // Data path carries no reset: nothing downstream looks at it unless the
  // matching valid bit is set.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_a         <= i_a;
      r_b         <= i_b;
      r_c         <= i_c;
      r_d         <= i_d;
      r_last_pipe <= {r_last_pipe[1:0], i_last};
      r_conj_pipe <= {r_conj_pipe[0], i_conj};
      r_ac        <= r_a * r_c;
      r_bd        <= r_b * r_d;
      r_ad        <= r_a * r_d;
      r_bc        <= r_b * r_c;
      r_re        <= r_conj_pipe[1] ? (w_ac + w_bd) : (w_ac - w_bd);
      r_im        <= r_conj_pipe[1] ? (w_bc - w_ad) : (w_ad + w_bc);
    end
  end

  assign o_term_re = r_re;
  assign o_term_im = r_im;
  assign o_last    = r_last_pipe[2];
  assign o_valid   = vld_pipe[2];

endmodule

// File: rtl/pipelined_complex_mac.sv
// Handshaked complex multiply-accumulate. Each accepted beat contributes
// A*B (or A*conj(B)); the terms of a frame are summed and one result is
// emitted on the frame's last beat, three edges after that beat is accepted.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input beat handshake
//   a, b, c, d                 signed operands, A = a+jb, B = c+jd
//   in_conj, in_last           per-beat conjugate select, end of frame
//   out_valid/out_ready        result handshake
//   out_re, out_im             signed frame sums (wrap modulo 2^OW)
//   out_ovf                    frame longer than 2^ACC_LOG2 beats
module pipelined_complex_mac import cmac_pkg::*; #(
  parameter  int DW       = DW_DEF,
  parameter  int ACC_LOG2 = ACC_LOG2_DEF,
  localparam int OW       = calc_ow(DW, ACC_LOG2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] c,
  input  logic signed [DW-1:0] d,
  input  logic                 in_conj,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic                 out_ovf
);

  localparam int TW = calc_tw(DW);
  localparam int CW = ACC_LOG2 + 2;
  localparam logic [CW-1:0] C_LIM = CW'(2 ** ACC_LOG2);
  localparam logic [CW-1:0] C_SAT = CW'(2 ** ACC_LOG2 + 1);

  logic                 w_en;
  logic signed [TW-1:0] w_term_re, w_term_im;
  logic                 w_s2_last, w_s2_valid;
  logic signed [OW-1:0] w_sum_re, w_sum_im;
  logic [CW-1:0]        w_cnt_inc;
  logic signed [OW-1:0] r_acc_re, r_acc_im;
  logic [CW-1:0]        r_cnt;

  // A held result freezes the entire pipe, so one enable drives every stage.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  complex_mult_core #(.DW(DW)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_en),
    .i_valid   (in_valid),
    .i_last    (in_last),
    .i_conj    (in_conj),
    .i_a       (a),
    .i_b       (b),
    .i_c       (c),
    .i_d       (d),
    .o_term_re (w_term_re),
    .o_term_im (w_term_im),
    .o_last    (w_s2_last),
    .o_valid   (w_s2_valid)
  );

  assign w_sum_re  = r_acc_re + {{(OW-TW){w_term_re[TW-1]}}, w_term_re};
  assign w_sum_im  = r_acc_im + {{(OW-TW){w_term_im[TW-1]}}, w_term_im};
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_re  <= '0;
      r_acc_im  <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_ovf   <= 1'b0;
    end else if (w_en) begin
      if (w_s2_valid && w_s2_last) begin
        // Closing beat: publish the sum and restart the frame in one edge.
        out_re    <= w_sum_re;
        out_im    <= w_sum_im;
        out_ovf   <= (w_cnt_inc > C_LIM);
        out_valid <= 1'b1;
        r_acc_re  <= '0;
        r_acc_im  <= '0;
        r_cnt     <= '0;
      end else begin
        if (w_s2_valid) begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
          // Saturate one past the limit so the flag stays set for long frames.
          if (r_cnt != C_SAT) r_cnt <= w_cnt_inc;
        end
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_complex_mac.sv
module tb_pipelined_complex_mac;

  localparam int DW = 8;
  localparam int OW = 21;

  logic                 clk = 1'b0;
  logic                 rst_n, in_valid, in_ready, in_conj, in_last;
  logic                 out_valid, out_ready, out_ovf;
  logic signed [DW-1:0] a, b, c, d;
  logic signed [OW-1:0] out_re, out_im;

  pipelined_complex_mac #(.DW(DW), .ACC_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .in_conj(in_conj), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OW-1:0] re, im;
    bit                   ovf;
    bit                   has_lit;
    longint               lre, lim;
    bit                   lovf;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0, n_bad = 0;
  longint m_re = 0, m_im = 0;
  int     m_n = 0;
  bit     lit_pend = 0, lit_ovf = 0;
  longint lit_re = 0, lit_im = 0;
  bit     rdy_rand = 0;
  bit     stall_prev = 0;
  logic signed [OW-1:0] hold_re, hold_im;
  bit     hold_ovf;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model and compare: observe everything mid-cycle, away from edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_re = 0; m_im = 0; m_n = 0; stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_re", out_re, hold_re);
        chk("stall_im", out_im, hold_im);
        chk("stall_ovf", out_ovf, hold_ovf);
      end
      chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got re=%0d im=%0d expected none", out_re, out_im);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_ovf", out_ovf, e.ovf);
          if (e.has_lit) begin
            chk("lit_re", out_re, e.lre);
            chk("lit_im", out_im, e.lim);
            chk("lit_ovf", out_ovf, e.lovf);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_re = out_re; hold_im = out_im; hold_ovf = out_ovf;
      if (in_valid && in_ready) begin
        longint ac, bd, ad, bc;
        ac = longint'(a) * longint'(c); bd = longint'(b) * longint'(d);
        ad = longint'(a) * longint'(d); bc = longint'(b) * longint'(c);
        m_re += in_conj ? (ac + bd) : (ac - bd);
        m_im += in_conj ? (bc - ad) : (ad + bc);
        m_n++;
        if (in_last) begin
          exp_t e;
          e.re = m_re[OW-1:0]; e.im = m_im[OW-1:0];
          e.ovf = (m_n > 16);
          e.has_lit = lit_pend; e.lre = lit_re; e.lim = lit_im; e.lovf = lit_ovf;
          lit_pend = 0;
          exp_q.push_back(e);
          m_re = 0; m_im = 0; m_n = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lit(input longint re, input longint im, input bit ovf);
    lit_pend = 1; lit_re = re; lit_im = im; lit_ovf = ovf;
  endtask

  task automatic send(input int av, input int bv, input int cv, input int dv,
                      input bit cj, input bit lst);
    int  n;
    bit  ok;
    a = DW'(av); b = DW'(bv); c = DW'(cv); d = DW'(dv);
    in_conj = cj; in_last = lst; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); ok = in_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    repeat (4) tick();
  endtask

  task automatic rnd8(output int v);
    v = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    int len, va, vb, vc, vd, n;
    rst_n = 1'b0; in_valid = 1'b0; in_conj = 1'b0; in_last = 1'b0;
    a = '0; b = '0; c = '0; d = '0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single beats, plain and conjugate, and the -128 corners.
    set_lit(23, 14, 0);    send(3, 4, 5, -2, 0, 1);
    set_lit(7, 26, 0);     send(3, 4, 5, -2, 1, 1);
    set_lit(0, 32768, 0);  send(-128, -128, -128, -128, 0, 1);
    set_lit(32768, 0, 0);  send(-128, -128, -128, -128, 1, 1);
    drain();

    // Three-beat frame with a bubble after the first beat.
    set_lit(-4, 13, 0);
    send(1, 1, 1, 0, 0, 0);
    tick();
    send(2, 0, 0, 1, 0, 0);
    send(1, 2, 3, 4, 0, 1);
    drain();

    // Backpressure: hold out_ready low for 5 cycles after the first result.
    fork
      begin
        send(1, 2, 3, 4, 0, 1);  send(-5, 6, 7, -8, 0, 1);
        send(9, -10, 11, 12, 1, 1); send(13, 14, -15, 16, 0, 1);
        send(-17, -18, 19, 20, 1, 1); send(21, 22, 23, -24, 0, 1);
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Overflow flag boundary: 16 and 17 beats of 127*127.
    set_lit(258064, 0, 0);
    for (int i = 0; i < 16; i++) send(127, 0, 127, 0, 0, i == 15);
    set_lit(274193, 0, 1);
    for (int i = 0; i < 17; i++) send(127, 0, 127, 0, 0, i == 16);
    drain();

    // Reset mid-frame discards the partial sum.
    send(50, 60, 70, 80, 0, 0);
    send(-50, 60, -70, 80, 1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_re", out_re, 0);
    chk("midrst_out_im", out_im, 0);
    tick();
    set_lit(23, 14, 0);
    send(3, 4, 5, -2, 0, 1);
    drain();

    // Random frames, random bubbles, random out_ready.
    rdy_rand = 1;
    for (int f = 0; f < 30; f++) begin
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        rnd8(va); rnd8(vb); rnd8(vc); rnd8(vd);
        send(va, vb, vc, vd, 1'($urandom_range(0, 1)), i == len - 1);
      end
    end
    rdy_rand = 0;
    out_ready = 1'b1;
    drain();

    chk("results_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_complex_mac.md
Name: pipelined_complex_mac

Overview:
- Parametrised, handshaked complex multiply-accumulate: computes (a+jb)·(c+jd), or (a+jb)·conj(c+jd), per beat.
- Sums the per-beat products over a frame delimited by in_last and emits one result per frame.
- Single-beat frames (in_last=1 on every beat) give a plain pipelined complex multiplier with valid/ready backpressure.
- Sits between sample sources and correlation/beamforming logic in the datapath.

Parameters:
- DW, 8, signed width of each input component.
- ACC_LOG2, 4, log2 of the maximum beats per frame without overflow flag (2^ACC_LOG2 = 16).
- OW, 2*DW+1+ACC_LOG2 (=21), signed output width; derived, not to be overridden.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat
- a  in  DW  signed real part of A
- b  in  DW  signed imaginary part of A
- c  in  DW  signed real part of B
- d  in  DW  signed imaginary part of B
- in_conj  in  1  1: multiply by conj(B) for this beat
- in_last  in  1  last beat of frame
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- out_re  out  OW  signed real sum
- out_im  out  OW  signed imaginary sum
- out_ovf  out  1  frame exceeded 2^ACC_LOG2 beats

Behaviour:
- Reset is synchronous on rst_n=0 at a clk edge. It clears:
  - out_valid, out_re, out_im, out_ovf to 0;
  - all stage valid bits, the accumulators and the beat counter.
- Reset mid-frame discards the partial sum and all in-flight beats; no result is produced for them.
- Handshake:
  - A beat is accepted when in_valid && in_ready at an edge.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - in_ready is 1 while rst_n=0 is being applied and out_valid=0.
- Stall: when out_valid && !out_ready, every pipeline register, valid bit, accumulator and counter holds. out_re/out_im/out_ovf stay stable until consumed.
- Pipeline stages, for a beat accepted at edge k:
  - S0 (edge k): register a, b, c, d, conj, last, valid.
  - S1 (k+1): four signed 2·DW products: ac, bd, ad, bc.
  - S2 (k+2), 2·DW+1 bits, sign-extended:
    - conj=0: re = ac−bd, im = ad+bc;
    - conj=1: re = ac+bd, im = bc−ad.
  - S3 (k+3): accumulate.
    - If S2 last=0: acc += term, cnt += 1 (cnt saturates at 2^ACC_LOG2+1).
    - If S2 last=1: out_re/out_im load acc+term, out_valid=1, out_ovf=(cnt+1 > 2^ACC_LOG2); acc and cnt clear to 0 on the same edge.
- Latency: a single-beat frame accepted at edge k shows out_valid=1 after edge k+3. Throughput is 1 beat/cycle with no stall.
- Bubbles (in_valid=0) propagate as invalid stages; the accumulator updates only on valid S2 beats.
- Simultaneous consume and new result: if out_valid && out_ready and S2 holds a last beat, the output registers reload on the same edge and out_valid stays 1.
- Arithmetic is two's complement. Accumulation wraps modulo 2^OW; out_ovf reports the wrap risk, and no saturation is applied.
- A frame containing only bubbles never emits.

Decomposition:
- Package cmac_pkg holds:
  - default DW and ACC_LOG2;
  - a function computing OW from DW/ACC_LOG2;
  - localparams for the S2 term width (2·DW+1) and the counter limit.
- Sub-module complex_mult_core implements S0–S2:
  - inputs: data, conj, last, valid, a stall enable;
  - outputs: term_re/term_im, last, valid.
- The top level keeps the accumulator, counter, output registers and handshake.

Test Plan (DW=8, ACC_LOG2=4, OW=21):
- Single beat, conj=0: a=3, b=4, c=5, d=−2, last=1, out_ready=1 → after edge k+3, out_re=23, out_im=14, out_ovf=0, out_valid for exactly one cycle.
- Same operands with conj=1 → out_re=7, out_im=26.
- Corner values, all inputs −128, last=1:
  - conj=0 → out_re=0, out_im=32768;
  - conj=1 → out_re=32768, out_im=0 (no sign error at 17 bits).
- Three-beat frame, (1+1j)(1+0j), (2+0j)(0+1j), (1+2j)(3+4j), last on the third, with a 1-cycle bubble between beats 1 and 2 → exactly one result: out_re=−4, out_im=13.
- Backpressure: six back-to-back single-beat frames with distinct operands; out_ready=0 for 5 cycles after the first out_valid → in_ready=0 during the stall, outputs stable, all six results in order, none lost or duplicated.
- Overflow flag, beats with a=127, c=127, b=d=0:
  - 16-beat frame → out_re=258064, out_ovf=0;
  - 17-beat frame → out_re=274193, out_ovf=1.
- Reset mid-frame: rst_n=0 for one edge after 2 beats of a frame → outputs 0; the next single-beat frame 3+4j·5−2j returns 23+14j, uncontaminated by the discarded beats.
